// File: rtl/superscalar_pkg.sv
// Shared encodings for the superscalar datapath: ALU opcodes, immediate formats,
// writeback result selects and the supported lane count.
package superscalar_pkg;

    localparam int MAX_ISSUE_W = 4;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_sel_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } res_sel_e;

endpackage

// File: rtl/dp_lane.sv
// One execute lane: immediate extension, operand-B mux, ALU, zero flag and
// writeback result mux. Purely combinational.
module dp_lane
    import superscalar_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  logic [1:0]      imm_src,
    input  logic [3:0]      alu_ctrl,
    input  logic            alu_src,
    input  logic [1:0]      result_src,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [XLEN-1:0] read_data,
    input  logic [XLEN-1:0] lane_pc,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] op_b;
    logic [4:0]      shamt;
    imm_sel_e        imm_sel;
    res_sel_e        res_sel;

    assign imm_sel = imm_sel_e'(imm_src);
    assign res_sel = res_sel_e'(result_src);

    always_comb begin
        imm32 = '0;
        case (imm_sel)
            IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Signed size cast sign-extends the 32-bit immediate to the datapath width
    assign imm_ext = XLEN'($signed(imm32));
    assign op_b    = alu_src ? imm_ext : src_b;
    assign shamt   = op_b[4:0];

    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            ALU_ADD:  alu_result = src_a + op_b;
            ALU_SUB:  alu_result = src_a - op_b;
            ALU_AND:  alu_result = src_a & op_b;
            ALU_OR:   alu_result = src_a | op_b;
            ALU_XOR:  alu_result = src_a ^ op_b;
            ALU_SLT:  alu_result = XLEN'($signed(src_a) < $signed(op_b));
            ALU_SLTU: alu_result = XLEN'(src_a < op_b);
            ALU_SLL:  alu_result = src_a << shamt;
            ALU_SRL:  alu_result = src_a >> shamt;
            ALU_SRA:  alu_result = $signed(src_a) >>> shamt;
            default:  alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

    always_comb begin
        result = '0;
        case (res_sel)
            RES_ALU: result = alu_result;
            RES_MEM: result = read_data;
            RES_PC4: result = lane_pc + XLEN'(4);
            RES_IMM: result = imm_ext;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/superscalar_datapath.sv
// Multi-issue datapath: fetch PC, execute (X) and writeback (W) registers around
// ISSUE_W dp_lane instances. Performance counters exist only with DP_PERF_CNT_EN.
module superscalar_datapath
    import superscalar_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              ISSUE_W  = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    redirect_valid,
    input  logic [XLEN-1:0]         redirect_target,
    input  logic [ISSUE_W-1:0]      in_valid,
    input  logic [ISSUE_W*32-1:0]   instr,
    input  logic [ISSUE_W*2-1:0]    imm_src,
    input  logic [ISSUE_W*4-1:0]    alu_ctrl,
    input  logic [ISSUE_W-1:0]      alu_src,
    input  logic [ISSUE_W*2-1:0]    result_src,
    input  logic [ISSUE_W*XLEN-1:0] src_a,
    input  logic [ISSUE_W*XLEN-1:0] src_b,
    input  logic [ISSUE_W*XLEN-1:0] read_data,
    output logic [XLEN-1:0]         pc,
    output logic [ISSUE_W-1:0]      x_zero,
    output logic [ISSUE_W*XLEN-1:0] x_alu_result,
    output logic [ISSUE_W*XLEN-1:0] x_write_data,
    output logic [ISSUE_W-1:0]      wb_valid,
    output logic [ISSUE_W*XLEN-1:0] wb_result,
    output logic [31:0]             cycle_cnt,
    output logic [31:0]             retired_cnt
);

    logic [XLEN-1:0]         pc_q;
    logic [ISSUE_W-1:0]      x_valid;
    logic [31:7]             x_instr [ISSUE_W];
    logic [XLEN-1:0]         x_pc    [ISSUE_W];
    logic [ISSUE_W*2-1:0]    x_imm_src;
    logic [ISSUE_W*4-1:0]    x_alu_ctrl;
    logic [ISSUE_W-1:0]      x_alu_src;
    logic [ISSUE_W*2-1:0]    x_result_src;
    logic [ISSUE_W*XLEN-1:0] x_src_a;
    logic [ISSUE_W*XLEN-1:0] x_src_b;
    logic [ISSUE_W*XLEN-1:0] x_read_data;
    logic [ISSUE_W*XLEN-1:0] x_result;
    logic [ISSUE_W-1:0]      wb_valid_q;
    logic [ISSUE_W*XLEN-1:0] wb_result_q;

    assign pc           = pc_q;
    assign x_write_data = x_src_b;
    assign wb_valid     = wb_valid_q;
    assign wb_result    = wb_result_q;

    // Redirect wins over stall so a taken branch is never lost while frozen
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= redirect_target;
        end else if (!stall) begin
            pc_q <= pc_q + XLEN'(4 * ISSUE_W);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_valid <= '0;
        end else if (redirect_valid) begin
            x_valid <= '0;
        end else if (!stall) begin
            x_valid <= in_valid;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ISSUE_W; i++) begin
                x_instr[i] <= '0;
                x_pc[i]    <= '0;
            end
            x_imm_src    <= '0;
            x_alu_ctrl   <= '0;
            x_alu_src    <= '0;
            x_result_src <= '0;
            x_src_a      <= '0;
            x_src_b      <= '0;
            x_read_data  <= '0;
        end else if (!stall) begin
            for (int i = 0; i < ISSUE_W; i++) begin
                x_instr[i] <= instr[i*32+7 +: 25];
                x_pc[i]    <= pc_q + XLEN'(4 * i);
            end
            x_imm_src    <= imm_src;
            x_alu_ctrl   <= alu_ctrl;
            x_alu_src    <= alu_src;
            x_result_src <= result_src;
            x_src_a      <= src_a;
            x_src_b      <= src_b;
            x_read_data  <= read_data;
        end
    end

    for (genvar g = 0; g < ISSUE_W; g++) begin : g_lane
        dp_lane #(.XLEN(XLEN)) u_lane (
            .instr      (x_instr[g]),
            .imm_src    (x_imm_src[g*2 +: 2]),
            .alu_ctrl   (x_alu_ctrl[g*4 +: 4]),
            .alu_src    (x_alu_src[g]),
            .result_src (x_result_src[g*2 +: 2]),
            .src_a      (x_src_a[g*XLEN +: XLEN]),
            .src_b      (x_src_b[g*XLEN +: XLEN]),
            .read_data  (x_read_data[g*XLEN +: XLEN]),
            .lane_pc    (x_pc[g]),
            .alu_result (x_alu_result[g*XLEN +: XLEN]),
            .result     (x_result[g*XLEN +: XLEN]),
            .zero       (x_zero[g])
        );
    end

    // W holds under stall even if a redirect lands in the same cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid_q  <= '0;
            wb_result_q <= '0;
        end else if (!stall) begin
            wb_valid_q  <= x_valid;
            wb_result_q <= x_result;
        end
    end

`ifdef DP_PERF_CNT_EN
    logic [31:0] cycle_q;
    logic [31:0] retired_q;
    logic [31:0] wb_pop;

    always_comb begin
        wb_pop = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            wb_pop = wb_pop + 32'(wb_valid_q[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q   <= '0;
            retired_q <= '0;
        end else begin
            cycle_q   <= cycle_q + 32'd1;
            retired_q <= retired_q + wb_pop;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign retired_cnt = retired_q;
`else
    assign cycle_cnt   = '0;
    assign retired_cnt = '0;
`endif

endmodule
